// File: rtl/spi_link_scheduler.sv
// spi_link_scheduler: round-robin frame arbiter between two pixel paths that
// serializes each granted byte as two nibbles onto a 4-line SPI link.
module spi_link_scheduler #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] pix0_in,
  input  logic       pix0_valid_in,
  input  logic       pix0_last_in,
  output logic       pix0_ready_out,
  input  logic [7:0] pix1_in,
  input  logic       pix1_valid_in,
  input  logic       pix1_last_in,
  output logic       pix1_ready_out,
  output logic [3:0] chip_data_out,
  output logic       chip_clk_out,
  output logic       chip_sel_out,
  output logic       final_pixel_out,
  output logic [1:0] grant_out,
  output logic       busy_out
);

  localparam int unsigned SLOT_LEN = 2 * CLK_DIV;
  localparam int unsigned CNT_MAX  = (SLOT_LEN > CS_GAP) ? SLOT_LEN : CS_GAP;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(SLOT_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_NIB_HI  = 3'd2,
    ST_NIB_LO  = 3'd3,
    ST_TAIL_HI = 3'd4,
    ST_TAIL_LO = 3'd5,
    ST_GAP     = 3'd6
  } state_e;

  // Control state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;   // NIB_HI waiting for the granted valid
  logic             owner_q, owner_d;   // 0 = path 0, 1 = path 1
  logic             ptr_q, ptr_d;       // round-robin tie winner
  logic [3:0]       lo_q, lo_d;         // low nibble of the captured pixel
  logic             last_q, last_d;     // captured pixel closes its frame

  // Registered outputs
  logic             sel_q, sel_d;
  logic             dclk_q, dclk_d;
  logic [3:0]       data_q, data_d;
  logic             final_q, final_d;
  logic             rdy0_q, rdy0_d;
  logic             rdy1_q, rdy1_d;
  logic [1:0]       grant_q, grant_d;
  logic             busy_q, busy_d;

  // Transition strobes shared between next-state and output logic
  logic             try_c;
  logic             launch_c;
  logic             to_lo_c;
  logic             gvalid_c;
  logic [7:0]       gpix_c;
  logic             glast_c;

  // Granted-path input mux
  assign gvalid_c = owner_q ? pix1_valid_in : pix0_valid_in;
  assign gpix_c   = owner_q ? pix1_in       : pix0_in;
  assign glast_c  = owner_q ? pix1_last_in  : pix0_last_in;

  // State register with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      lo_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      lo_q    <= lo_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: slot sequencing, arbitration and pixel capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    lo_d     = lo_q;
    last_d   = last_q;
    try_c    = 1'b0;
    launch_c = 1'b0;
    to_lo_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pix0_valid_in || pix1_valid_in) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          owner_d = (pix0_valid_in && pix1_valid_in) ? ptr_q : pix1_valid_in;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_END) try_c = 1'b1;
        else                    cnt_d = cnt_q + CNT_ONE;
      end
      ST_NIB_HI: begin
        if (stall_q) begin
          try_c = 1'b1;
        end else if (cnt_q == SLOT_END) begin
          state_d = ST_NIB_LO;
          cnt_d   = '0;
          to_lo_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_NIB_LO: begin
        if (cnt_q == SLOT_END) begin
          if (last_q) begin
            state_d = ST_TAIL_HI;
            cnt_d   = '0;
          end else begin
            try_c = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_TAIL_HI: begin
        if (cnt_q == SLOT_END) begin
          state_d = ST_TAIL_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_TAIL_LO: begin
        if (cnt_q == SLOT_END) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          ptr_d   = ~owner_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_END) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        stall_d = 1'b0;
      end
    endcase

    // High-nibble launch attempt; a missing valid parks in NIB_HI with DCLK low
    if (try_c) begin
      state_d  = ST_NIB_HI;
      cnt_d    = '0;
      launch_c = gvalid_c;
      stall_d  = !gvalid_c;
    end

    if (launch_c) begin
      lo_d   = gpix_c[3:0];
      last_d = glast_c;
    end
  end

  // Output logic: values the link pins take after this edge
  always_comb begin
    sel_d   = 1'b1;
    dclk_d  = 1'b0;
    data_d  = data_q;
    final_d = final_q;
    rdy0_d  = 1'b0;
    rdy1_d  = 1'b0;
    grant_d = 2'b00;
    busy_d  = (state_d != ST_IDLE);

    if (state_d inside {ST_SETUP, ST_NIB_HI, ST_NIB_LO, ST_TAIL_HI, ST_TAIL_LO}) begin
      sel_d   = 1'b0;
      grant_d = owner_d ? 2'b10 : 2'b01;
    end

    if (state_d inside {ST_NIB_HI, ST_NIB_LO, ST_TAIL_HI, ST_TAIL_LO}) begin
      dclk_d = !stall_d && (cnt_d >= HALF);
    end

    if (launch_c) begin
      data_d  = gpix_c[7:4];
      final_d = glast_c;
      rdy0_d  = !owner_q;
      rdy1_d  = owner_q;
    end else if (to_lo_c) begin
      data_d = lo_q;
    end else if (!(state_d inside {ST_NIB_HI, ST_NIB_LO})) begin
      data_d  = '0;
      final_d = 1'b0;
    end
  end

  // Output registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sel_q   <= 1'b1;
      dclk_q  <= 1'b0;
      data_q  <= '0;
      final_q <= 1'b0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      dclk_q  <= dclk_d;
      data_q  <= data_d;
      final_q <= final_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign chip_sel_out    = sel_q;
  assign chip_clk_out    = dclk_q;
  assign chip_data_out   = data_q;
  assign final_pixel_out = final_q;
  assign pix0_ready_out  = rdy0_q;
  assign pix1_ready_out  = rdy1_q;
  assign grant_out       = grant_q;
  assign busy_out        = busy_q;

endmodule

// File: tb/tb_spi_link_scheduler.sv
// Directed bench for spi_link_scheduler with CLK_DIV=2, CS_GAP=3.
module tb_spi_link_scheduler;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CS_GAP  = 3;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] pix0_in, pix1_in;
  logic       pix0_valid_in, pix1_valid_in;
  logic       pix0_last_in, pix1_last_in;
  logic       pix0_ready_out, pix1_ready_out;
  logic [3:0] chip_data_out;
  logic       chip_clk_out, chip_sel_out, final_pixel_out, busy_out;
  logic [1:0] grant_out;

  spi_link_scheduler #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pix0_in         (pix0_in),
    .pix0_valid_in   (pix0_valid_in),
    .pix0_last_in    (pix0_last_in),
    .pix0_ready_out  (pix0_ready_out),
    .pix1_in         (pix1_in),
    .pix1_valid_in   (pix1_valid_in),
    .pix1_last_in    (pix1_last_in),
    .pix1_ready_out  (pix1_ready_out),
    .chip_data_out   (chip_data_out),
    .chip_clk_out    (chip_clk_out),
    .chip_sel_out    (chip_sel_out),
    .final_pixel_out (final_pixel_out),
    .grant_out       (grant_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_tests, n_fail, cyc;
  logic [8:0]  q0[$], q1[$];              // {last, pixel} per source
  int unsigned pops0, pops1, k1;
  bit          drop1;
  int unsigned nib_q[$];                  // {final, nibble} per DCLK rise
  int unsigned rdy0_c[$], rdy1_c[$], cs_runs[$], cs_fall_c[$], owners[$];
  int unsigned cs_run, low_run, max_low, gap_cyc, bad_rdy;
  logic        prev_dclk;
  int unsigned exp_q[$];
  bit          timed_out;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned at(input int unsigned q[$], input int unsigned i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic mon_clear();
    nib_q.delete(); rdy0_c.delete(); rdy1_c.delete();
    cs_runs.delete(); cs_fall_c.delete(); owners.delete();
    cs_run = 0; low_run = 0; max_low = 0; gap_cyc = 0; bad_rdy = 0;
    prev_dclk = 1'b0;
  endtask

  // One clock: sample link outputs at the falling edge, then update sources
  task automatic step();
    @(negedge clk_in);
    cyc++;
    if (!chip_sel_out) begin
      if (cs_run == 0) begin
        cs_fall_c.push_back(cyc);
        owners.push_back(32'(grant_out));
      end
      cs_run++;
      if (!chip_clk_out) low_run++;
      else begin
        if (low_run > max_low) max_low = low_run;
        low_run = 0;
      end
    end else begin
      if (cs_run != 0) cs_runs.push_back(cs_run);
      cs_run = 0;
      if (low_run > max_low) max_low = low_run;
      low_run = 0;
      if (busy_out) gap_cyc++;
    end
    if (chip_clk_out && !prev_dclk) nib_q.push_back(32'({final_pixel_out, chip_data_out}));
    prev_dclk = chip_clk_out;
    if ((pix0_ready_out && grant_out != 2'b01) || (pix1_ready_out && grant_out != 2'b10)) bad_rdy++;
    if (pix0_ready_out) rdy0_c.push_back(cyc);
    if (pix1_ready_out) rdy1_c.push_back(cyc);

    if (pix0_ready_out && q0.size() != 0) begin q0.delete(0); pops0++; end
    if (pix1_ready_out && q1.size() != 0) begin q1.delete(0); pops1++; k1 = 0; end
    else k1++;

    pix0_valid_in = (q0.size() != 0);
    pix0_in       = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
    pix0_last_in  = (q0.size() != 0) ? q0[0][8]   : 1'b0;
    pix1_valid_in = (q1.size() != 0) && !(drop1 && pops1 == 1 && k1 >= 7 && k1 <= 13);
    pix1_in       = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
    pix1_last_in  = (q1.size() != 0) ? q1[0][8]   : 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    timed_out = 1'b1;
    for (int i = 0; i < int'(budget); i++) begin
      step();
      if (q0.size() == 0 && q1.size() == 0 && !busy_out && chip_sel_out) begin
        timed_out = 1'b0;
        break;
      end
    end
    check({tag, "_timeout"}, 32'(timed_out), 0);
  endtask

  task automatic check_stream(input string tag, input int unsigned e[$]);
    check({tag, "_len"}, nib_q.size(), e.size());
    foreach (e[i]) check($sformatf("%s_%0d", tag, i), at(nib_q, i), e[i]);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    step();
    step();
    q0.delete(); q1.delete();
    pops0 = 0; pops1 = 0; k1 = 0; drop1 = 1'b0;
    rst_in = 1'b1;
    step();
    mon_clear();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    pops0 = 0; pops1 = 0; k1 = 0; drop1 = 1'b0;
    rst_in = 1'b0;
    pix0_in = '0; pix0_valid_in = 1'b0; pix0_last_in = 1'b0;
    pix1_in = '0; pix1_valid_in = 1'b0; pix1_last_in = 1'b0;
    mon_clear();
    step();
    step();
    check("rst_cs",    32'(chip_sel_out),    1);
    check("rst_dclk",  32'(chip_clk_out),    0);
    check("rst_data",  32'(chip_data_out),   0);
    check("rst_final", 32'(final_pixel_out), 0);
    check("rst_rdy",   32'({pix1_ready_out, pix0_ready_out}), 0);
    check("rst_grant", 32'(grant_out),       0);
    check("rst_busy",  32'(busy_out),        0);
    rst_in = 1'b1;
    step();
    mon_clear();

    // Three-pixel frame on path 0
    q0.push_back(9'h0A5); q0.push_back(9'h03C); q0.push_back(9'h1F0);
    wait_done("s1", 300);
    exp_q = '{32'h0A, 32'h05, 32'h03, 32'h0C, 32'h1F, 32'h10, 32'h00, 32'h00};
    check_stream("s1_nib", exp_q);
    check("s1_rdy_cnt",  rdy0_c.size(), 3);
    check("s1_rdy_gap0", at(rdy0_c, 1) - at(rdy0_c, 0), 8);
    check("s1_rdy_gap1", at(rdy0_c, 2) - at(rdy0_c, 1), 8);
    check("s1_rdy1_cnt", rdy1_c.size(), 0);
    check("s1_cs_runs",  cs_runs.size(), 1);
    check("s1_cs_low",   at(cs_runs, 0), 34);
    check("s1_rdy_lat",  at(rdy0_c, 0) - at(cs_fall_c, 0), 2);
    check("s1_owner",    at(owners, 0), 1);

    // Single-pixel frame
    mon_clear();
    q0.push_back(9'h181);
    wait_done("s4", 200);
    exp_q = '{32'h18, 32'h11, 32'h00, 32'h00};
    check_stream("s4_nib", exp_q);
    check("s4_cs_low", at(cs_runs, 0), 18);

    // Both paths contend from reset, two frames each
    do_reset();
    q0.push_back(9'h012); q0.push_back(9'h134); q0.push_back(9'h09A); q0.push_back(9'h1BC);
    q1.push_back(9'h056); q1.push_back(9'h178); q1.push_back(9'h0DE); q1.push_back(9'h1F1);
    wait_done("s2", 600);
    check("s2_bursts", owners.size(), 4);
    check("s2_own0", at(owners, 0), 1);
    check("s2_own1", at(owners, 1), 2);
    check("s2_own2", at(owners, 2), 1);
    check("s2_own3", at(owners, 3), 2);
    check("s2_gap",  gap_cyc, 4 * CS_GAP);
    check("s2_bad_rdy", bad_rdy, 0);
    exp_q = '{32'h01, 32'h02, 32'h13, 32'h14, 32'h00, 32'h00,
              32'h05, 32'h06, 32'h17, 32'h18, 32'h00, 32'h00,
              32'h09, 32'h0A, 32'h1B, 32'h1C, 32'h00, 32'h00,
              32'h0D, 32'h0E, 32'h1F, 32'h11, 32'h00, 32'h00};
    check_stream("s2_nib", exp_q);

    // Path 1 valid withheld for 7 cycles at the second launch
    do_reset();
    drop1 = 1'b1;
    q1.push_back(9'h0C3); q1.push_back(9'h05A); q1.push_back(9'h17E);
    wait_done("s3", 300);
    drop1 = 1'b0;
    exp_q = '{32'h0C, 32'h03, 32'h05, 32'h0A, 32'h17, 32'h1E, 32'h00, 32'h00};
    check_stream("s3_nib", exp_q);
    check("s3_rdy_cnt",  rdy1_c.size(), 3);
    check("s3_rdy_gap0", at(rdy1_c, 1) - at(rdy1_c, 0), 15);
    check("s3_rdy_gap1", at(rdy1_c, 2) - at(rdy1_c, 1), 8);
    check("s3_cs_low",   at(cs_runs, 0), 41);
    check("s3_max_low",  max_low, CLK_DIV + 7);

    // Reset during the low nibble of pixel 2; pointer was at path 1
    do_reset();
    q0.push_back(9'h181);
    wait_done("s5a", 200);
    q0.push_back(9'h011); q0.push_back(9'h027); q0.push_back(9'h133);
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (pops0 == 3) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("s5_rdy_timeout", 32'(timed_out), 0);
    check("s5_hi_nib", 32'(chip_data_out), 2);
    repeat (5) step();
    check("s5_lo_nib", 32'(chip_data_out), 7);
    check("s5_lo_cs",  32'(chip_sel_out), 0);
    rst_in = 1'b0;
    step();
    check("s5_rst_cs",    32'(chip_sel_out),    1);
    check("s5_rst_dclk",  32'(chip_clk_out),    0);
    check("s5_rst_data",  32'(chip_data_out),   0);
    check("s5_rst_grant", 32'(grant_out),       0);
    check("s5_rst_busy",  32'(busy_out),        0);
    check("s5_rst_final", 32'(final_pixel_out), 0);
    q0.delete(); q1.delete();
    pops0 = 0; pops1 = 0; k1 = 0;
    rst_in = 1'b1;
    step();
    mon_clear();
    q0.push_back(9'h144); q1.push_back(9'h155);
    wait_done("s5b", 300);
    check("s5_own0", at(owners, 0), 1);
    check("s5_own1", at(owners, 1), 2);
    exp_q = '{32'h14, 32'h14, 32'h00, 32'h00, 32'h15, 32'h15, 32'h00, 32'h00};
    check_stream("s5_nib", exp_q);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
